stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control FSM for the mm:ss stopwatch counter chain (four cascaded BCD digits: sec0 limit 9, sec1 limit 5, min0 limit 9, min1 limit 5). It turns one-pulse button events and the 1 Hz tick into the chain's `count_enable` and `rst_state` controls. It adds a lap function: the displayed time freezes while counting continues. It also saturates at 59:59 instead of wrapping.

## Interface
Parameters:
- none

Ports:
- `clk` input 1: global clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `tick_1hz` input 1: one-`clk` pulse per second from the divider.
- `btn_ss` input 1: start/stop event, one-cycle pulse, already debounced.
- `btn_lr` input 1: lap/reset event, one-cycle pulse, already debounced.
- `sec0`, `sec1`, `min0`, `min1` input 4 each: live BCD digits from the counter chain.
- `count_enable` output 1: increment request to the chain's least-significant digit.
- `rst_state` output 1: synchronous clear request to all four digits.
- `disp_sec0`, `disp_sec1`, `disp_min0`, `disp_min1` output 4 each: digits to display.
- `lap_active` output 1: high while the display is frozen.
- `full` output 1: high while the live count is 59:59.

## Operation
- State register with four states: IDLE, RUN, PAUSE, LAP.
  - Reset value: IDLE.
  - Changes only on the rising `clk` edge.
- Same-cycle events: if `btn_ss` and `btn_lr` are both high in one cycle, `btn_ss` wins and `btn_lr` is ignored.
- Transitions:
  - IDLE + `btn_ss` -> RUN. `btn_lr` in IDLE is ignored.
  - RUN + `btn_ss` -> PAUSE.
  - RUN + `btn_lr` -> LAP. On that same edge, capture the live digits into the lap register.
  - LAP + `btn_lr` -> RUN (display released).
  - LAP + `btn_ss` -> PAUSE (display released).
  - PAUSE + `btn_ss` -> RUN. Not taken if `full`; PAUSE is held instead.
  - PAUSE + `btn_lr` -> IDLE.
  - RUN or LAP with `full`=1 -> PAUSE on the next edge, unconditionally. Button events in that cycle are ignored; `btn_lr` in LAP does not reach RUN.
- Output definitions:
  - `full` = (`min1`==5 && `min0`==9 && `sec1`==5 && `sec0`==9), combinational.
  - `count_enable` = `tick_1hz` && (state==RUN || state==LAP) && !`full`, combinational, so it lands in the tick cycle. This guarantees the chain never wraps from 59:59 to 00:00.
  - `rst_state` = (state==IDLE), decoded from the state register. The chain therefore holds 00:00 throughout IDLE, including immediately after reset.
  - `lap_active` = (state==LAP).
- Lap register: 16 bits, reset value 0, loaded only on the RUN->LAP edge.
- Display mux: `disp_*` = lap register when `lap_active`, otherwise the live digits. Combinational.

## Timing
- Values after `rst_n` deassertion (before the first edge):
  - state IDLE, `rst_state`=1, `count_enable`=0, `lap_active`=0, lap register 0.
  - `disp_*` follows the live inputs.
- Asserting `rst_n` mid-operation forces IDLE asynchronously, from any state. `rst_state` rises with no clock needed.
- Button-to-state latency: 1 edge. A tick in the same cycle as the `btn_ss` that leaves RUN still produces `count_enable`=1, because the state is still RUN in that cycle.
- A tick in the same cycle as IDLE->RUN produces no increment; the first count happens on the next tick.
- Lap snapshot takes the live digits before any increment issued in the same cycle.
- Saturation sequence:
  - The chain reaches 59:59 on tick N.
  - `full`=1 the following cycle; the state enters PAUSE one edge later.
  - No increment occurs in between, since `count_enable` is gated by `full`.

## Test plan
- Reset, then `btn_ss`, then 3 ticks -> `count_enable` pulses exactly 3 times; digits read 00:03. `rst_state` is 1 until the `btn_ss` edge, then 0.
- RUN at 00:07, `btn_lr`, then 5 ticks -> `lap_active`=1 and `disp` holds 00:07 while the live digits reach 00:12. A second `btn_lr` -> `disp` shows 00:12.
- RUN, `btn_ss`, 4 ticks, `btn_ss`, 1 tick -> no enables while paused; count advances by exactly 1 after resume.
- PAUSE at 01:23, `btn_lr` -> IDLE; `rst_state`=1 on the following cycle; live digits read 00:00. Further `btn_lr` pulses are ignored.
- Preload 59:58 in RUN, 3 ticks -> one enable (to 59:59), then `full`=1, state PAUSE, digits stay 59:59. `btn_ss` stays in PAUSE.
- `btn_ss` and `btn_lr` in the same cycle from RUN -> PAUSE, no lap capture. Assert `rst_n` low from LAP -> immediate IDLE, `lap_active`=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Control FSM for the mm:ss BCD stopwatch chain: start/stop, lap freeze,
// clear, and saturation at 59:59.
module stopwatch_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] sec0,
    input  logic [3:0] sec1,
    input  logic [3:0] min0,
    input  logic [3:0] min1,
    output logic       count_enable,
    output logic       rst_state,
    output logic [3:0] disp_sec0,
    output logic [3:0] disp_sec1,
    output logic [3:0] disp_min0,
    output logic [3:0] disp_min1,
    output logic       lap_active,
    output logic       full
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    state_t      r_state;
    logic [15:0] r_lap;
    logic [15:0] w_live;
    logic [15:0] w_disp;
    logic        w_full;
    logic        w_counting;

    assign w_live     = {min1, min0, sec1, sec0};
    assign w_full     = (min1 == 4'd5) && (min0 == 4'd9) && (sec1 == 4'd5) && (sec0 == 4'd9);
    assign w_counting = (r_state == RUN) || (r_state == LAP);

    // Gating by full keeps the chain from ever wrapping 59:59 -> 00:00.
    assign count_enable = tick_1hz && w_counting && !w_full;
    assign rst_state    = (r_state == IDLE);
    assign lap_active   = (r_state == LAP);
    assign full         = w_full;

    assign w_disp    = lap_active ? r_lap : w_live;
    assign disp_sec0 = w_disp[3:0];
    assign disp_sec1 = w_disp[7:4];
    assign disp_min0 = w_disp[11:8];
    assign disp_min1 = w_disp[15:12];

    // btn_ss has priority over btn_lr; full overrides buttons while counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_lap   <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (btn_ss) r_state <= RUN;
                end
                RUN: begin
                    if (w_full || btn_ss) begin
                        r_state <= PAUSE;
                    end else if (btn_lr) begin
                        r_state <= LAP;
                        r_lap   <= w_live;
                    end
                end
                LAP: begin
                    if (w_full || btn_ss) r_state <= PAUSE;
                    else if (btn_lr)      r_state <= RUN;
                end
                PAUSE: begin
                    if (btn_ss) begin
                        if (!w_full) r_state <= RUN;
                    end else if (btn_lr) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
